prefix_add_pipe: RTL and testbench

Parametrised, pipelined Sklansky parallel-prefix adder/subtractor with valid/ready handshakes on both sides. It generalises the team's combinational 8-bit prefix adder in three ways: any power-of-two width, a selectable number of prefix levels per pipeline register, and carry-in, carry-out and subtract mode. It sits in the datapath wherever a wide add must close timing at full clock rate and sustain one operation per cycle.

---
 rtl/prefix_add_pkg.sv | 27 ++
 rtl/prefix_add_pipe_black_cell.sv | 14 +
 rtl/prefix_add_pipe.sv | 148 ++++++++++++++
 tb/tb_prefix_add_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_add_pkg.sv
// Shared constants, helper functions and stage types for the pipelined prefix adder.
package prefix_add_pkg;

  // Per-stage control: valid bit plus the carry-in needed for the sum of bit 0.
  typedef struct packed {
    logic valid;
    logic c0;
  } stage_ctrl_t;

  function automatic int prefix_levels(input int width);
    return $clog2(width);
  endfunction

  function automatic int prefix_stages(input int width, input int reg_every);
    int levels;
    levels = $clog2(width);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  function automatic bit prefix_params_legal(input int width, input int reg_every);
    int levels;
    levels = $clog2(width);
    return (width >= 4) && (width <= 64) && ((1 << levels) == width) &&
           (reg_every >= 1) && (reg_every <= levels);
  endfunction

endpackage

// File: rtl/prefix_add_pipe_black_cell.sv
// Sklansky black cell: merges a high group (hi) with the adjacent lower group (lo).
module prefix_black_cell (
  input  logic hi_p,
  input  logic hi_g,
  input  logic lo_p,
  input  logic lo_g,
  output logic p,
  output logic g
);

  assign g = hi_g | (hi_p & lo_g);
  assign p = hi_p & lo_p;

endmodule

// File: rtl/prefix_add_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready on both sides.
// Optional out_ovf/out_zero flags are built only when PREFIX_ADD_FLAGS_EN is defined.
module prefix_add_pipe
  import prefix_add_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PREFIX_ADD_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int L = prefix_levels(WIDTH);
  localparam int S = prefix_stages(WIDTH, REG_EVERY);

  if (!prefix_params_legal(WIDTH, REG_EVERY)) begin : g_bad_params
    $error("prefix_add_pipe: illegal WIDTH/REG_EVERY combination");
  end

  // x is the bitwise propagate kept for the final sum; p/g are the group terms.
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
  } stage_t;

  stage_t           stage_reg  [0:S-1];
  stage_t           stage_next [0:S-1];
  logic [WIDTH-1:0] lvl_in_p   [0:L-1];
  logic [WIDTH-1:0] lvl_in_g   [0:L-1];
  logic [WIDTH-1:0] lvl_out_p  [0:L-1];
  logic [WIDTH-1:0] lvl_out_g  [0:L-1];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Carry-in is folded into g[0] so every group generate is a true carry.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    c0_in   = in_sub | in_cin;
    x_in    = in_a ^ b_eff;
    g_in    = in_a & b_eff;
    g_in[0] = g_in[0] | (x_in[0] & c0_in);
  end

  assign stage_next[0] = {in_valid & in_ready, c0_in, x_in, x_in, g_in};

  genvar gi, gj;
  for (gi = 0; gi < L; gi++) begin : g_level
    if (gi % REG_EVERY == 0) begin : g_from_reg
      assign lvl_in_p[gi] = stage_reg[gi / REG_EVERY].p;
      assign lvl_in_g[gi] = stage_reg[gi / REG_EVERY].g;
    end else begin : g_from_comb
      assign lvl_in_p[gi] = lvl_out_p[gi-1];
      assign lvl_in_g[gi] = lvl_out_g[gi-1];
    end

    for (gj = 0; gj < WIDTH; gj++) begin : g_bit
      if (((gj >> gi) & 1) == 1) begin : g_cell
        localparam int J = ((gj >> gi) << gi) - 1;
        prefix_black_cell u_cell (
          .hi_p (lvl_in_p[gi][gj]),
          .hi_g (lvl_in_g[gi][gj]),
          .lo_p (lvl_in_p[gi][J]),
          .lo_g (lvl_in_g[gi][J]),
          .p    (lvl_out_p[gi][gj]),
          .g    (lvl_out_g[gi][gj])
        );
      end else begin : g_pass
        assign lvl_out_p[gi][gj] = lvl_in_p[gi][gj];
        assign lvl_out_g[gi][gj] = lvl_in_g[gi][gj];
      end
    end
  end

  for (gi = 1; gi < S; gi++) begin : g_stage
    assign stage_next[gi] = {stage_reg[gi-1].ctrl, stage_reg[gi-1].x,
                             lvl_out_p[gi*REG_EVERY-1], lvl_out_g[gi*REG_EVERY-1]};
  end

  // Group propagates of the final level feed nothing once all carries are known.
  logic unused_final_p;
  assign unused_final_p = ^lvl_out_p[L-1];

  assign carry    = {lvl_out_g[L-1], stage_reg[S-1].ctrl.c0};
  assign sum_next = stage_reg[S-1].x ^ carry[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        stage_reg[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < S; k++) begin
        stage_reg[k] <= stage_next[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (adv) begin
      out_valid <= stage_reg[S-1].ctrl.valid;
      out_sum   <= sum_next;
      out_cout  <= carry[WIDTH];
    end
  end

`ifdef PREFIX_ADD_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (adv) begin
      out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      out_zero <= ~|sum_next;
    end
  end
`endif

endmodule

// File: tb/tb_prefix_add_pipe.sv
// Directed bench for prefix_add_pipe: a 16-bit/1-level build and an 8-bit/3-level build.
module tb_prefix_add_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        d16_in_valid, d16_in_ready, d16_in_cin, d16_in_sub;
  logic [15:0] d16_in_a, d16_in_b, d16_out_sum;
  logic        d16_out_valid, d16_out_ready, d16_out_cout;
  logic        d8_in_valid, d8_in_ready, d8_in_cin, d8_in_sub;
  logic [7:0]  d8_in_a, d8_in_b, d8_out_sum;
  logic        d8_out_valid, d8_out_ready, d8_out_cout;
`ifdef PREFIX_ADD_FLAGS_EN
  logic        d16_out_ovf, d16_out_zero, d8_out_ovf, d8_out_zero;
`endif

  prefix_add_pipe #(.WIDTH(16), .REG_EVERY(1)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .in_a(d16_in_a), .in_b(d16_in_b), .in_cin(d16_in_cin), .in_sub(d16_in_sub),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready),
    .out_sum(d16_out_sum), .out_cout(d16_out_cout)
`ifdef PREFIX_ADD_FLAGS_EN
    , .out_ovf(d16_out_ovf), .out_zero(d16_out_zero)
`endif
  );

  prefix_add_pipe #(.WIDTH(8), .REG_EVERY(3)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_a(d8_in_a), .in_b(d8_in_b), .in_cin(d8_in_cin), .in_sub(d8_in_sub),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_sum(d8_out_sum), .out_cout(d8_out_cout)
`ifdef PREFIX_ADD_FLAGS_EN
    , .out_ovf(d8_out_ovf), .out_zero(d8_out_zero)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    d16_in_valid = 1'b1; d16_in_a = 16'h0001; d16_in_b = 16'h0001;
    d16_in_cin = 1'b0; d16_in_sub = 1'b0; d16_out_ready = 1'b0;
    d8_in_valid = 1'b0; d8_in_a = '0; d8_in_b = '0; d8_in_cin = 1'b0;
    d8_in_sub = 1'b0; d8_out_ready = 1'b1;
    #1;
    checks++;
    if (d16_out_valid !== 1'b0 || d16_out_sum !== 16'h0 || d16_out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sum=%h cout=%b, want 0/0000/0",
               d16_out_valid, d16_out_sum, d16_out_cout);
    end
    checks++;
    if (d16_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", d16_in_ready);
    end
`ifdef PREFIX_ADD_FLAGS_EN
    checks++;
    if (d16_out_ovf !== 1'b0 || d16_out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b zero=%b want 0/0", d16_out_ovf, d16_out_zero);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d16_in_valid = 1'b0;
    d16_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (d16_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_beat_ignored: cycle %0d valid=%b want 0", k, d16_out_valid);
      end
    end
    $display("test_reset: beat offered during reset was not accepted");
  endtask

  task automatic run_single16(input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub,
                              input logic [15:0] es, input logic ec,
                              input logic eo, input logic ez, input string name);
    @(negedge clk);
    d16_out_ready = 1'b1;
    d16_in_valid = 1'b1; d16_in_a = a; d16_in_b = b; d16_in_cin = cin; d16_in_sub = sub;
    #1;
    checks++;
    if (d16_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", name, d16_in_ready);
    end
    @(negedge clk);
    d16_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (d16_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid: after %0d edges valid=%b want 0", name, k, d16_out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (d16_out_valid !== 1'b1 || d16_out_sum !== es || d16_out_cout !== ec) begin
      errors++;
      $display("FAIL %s result: valid=%b sum=%h cout=%b, want 1/%h/%b",
               name, d16_out_valid, d16_out_sum, d16_out_cout, es, ec);
    end
`ifdef PREFIX_ADD_FLAGS_EN
    checks++;
    if (d16_out_ovf !== eo || d16_out_zero !== ez) begin
      errors++;
      $display("FAIL %s flags: ovf=%b zero=%b, want %b/%b", name, d16_out_ovf, d16_out_zero, eo, ez);
    end
`endif
    $display("%s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b (expect sum=%h cout=%b ovf=%b zero=%b)",
             name, a, b, cin, sub, d16_out_sum, d16_out_cout, es, ec, eo, ez);
  endtask

  task automatic test_add_sub();
    run_single16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap");
    run_single16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    run_single16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_single16(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0, "sub_cin_ignored");
    run_single16(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0, "add_cin");
    run_single16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6] = '{16'h0001, 16'h1000, 16'h8000, 16'h0100, 16'h0000, 16'hABCD};
    logic [15:0] vb [6] = '{16'h0002, 16'h2000, 16'h8000, 16'h0001, 16'h0001, 16'h1111};
    logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] es [6] = '{16'h0003, 16'h3001, 16'h0000, 16'h00FF, 16'hFFFF, 16'hBCDE};
    logic        ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    bit first_seen = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (d16_out_valid === 1'b1 && !first_seen) begin
        first_seen = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        d16_out_ready = 1'b0;
        stall_left--;
      end else begin
        d16_out_ready = 1'b1;
      end
      if (sent < 6) begin
        d16_in_valid = 1'b1; d16_in_a = va[sent]; d16_in_b = vb[sent];
        d16_in_cin = vc[sent]; d16_in_sub = vs[sent];
      end else begin
        d16_in_valid = 1'b0;
      end
      #1;
      if (d16_out_ready === 1'b0) begin
        checks++;
        if (d16_in_ready !== 1'b0 || d16_out_valid !== 1'b1 || d16_out_sum !== es[got]) begin
          errors++;
          $display("FAIL b2b_stall: in_ready=%b valid=%b sum=%h, want 0/1/%h",
                   d16_in_ready, d16_out_valid, d16_out_sum, es[got]);
        end
      end
      if (d16_out_valid === 1'b1 && d16_out_ready === 1'b1) begin
        checks++;
        if (d16_out_sum !== es[got] || d16_out_cout !== ec[got]) begin
          errors++;
          $display("FAIL b2b_result%0d: sum=%h cout=%b, want %h/%b",
                   got, d16_out_sum, d16_out_cout, es[got], ec[got]);
        end
        $display("b2b result %0d: sum=%h cout=%b", got, d16_out_sum, d16_out_cout);
        got++;
      end
      if (d16_in_valid === 1'b1 && d16_in_ready === 1'b1) sent++;
    end
    @(negedge clk);
    d16_in_valid = 1'b0;
    d16_out_ready = 1'b1;
    checks++;
    if (got != 6 || sent != 6) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d got=%0d, want 6/6", sent, got);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (d16_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_duplicate: extra valid result sum=%h", d16_out_sum);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    d16_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d16_in_valid = 1'b1; d16_in_a = 16'h0100 + 16'(k); d16_in_b = 16'h0001;
      d16_in_cin = 1'b0; d16_in_sub = 1'b0;
      @(negedge clk);
    end
    d16_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (d16_out_valid !== 1'b0 || d16_out_sum !== 16'h0) begin
      errors++;
      $display("FAIL inflight_reset: valid=%b sum=%h, want 0/0000", d16_out_valid, d16_out_sum);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (d16_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL inflight_stale: stale result sum=%h appeared", d16_out_sum);
      end
    end
    $display("test_reset_inflight: three in-flight beats discarded");
    run_single16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  typedef struct packed {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
  } vec8_t;

  task automatic test_sweep8();
    vec8_t       vq [$];
    logic [10:0] eq [$];
    logic [7:0]  blist [8];
    vec8_t       v;
    logic [7:0]  bm;
    logic [8:0]  full;
    logic [10:0] exp_v;
    logic [10:0] got_v;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int total;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 256; a++) begin
          blist = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'(a), ~8'(a), 8'(a) ^ 8'h55};
          for (int i = 0; i < 8; i++) vq.push_back({1'(s), 1'(c), 8'(a), blist[i]});
        end
    total = vq.size();
    while (got < total && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      d8_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < total) begin
        v = vq[sent];
        d8_in_valid = 1'b1; d8_in_a = v.a; d8_in_b = v.b; d8_in_cin = v.cin; d8_in_sub = v.sub;
      end else begin
        d8_in_valid = 1'b0;
      end
      #1;
      if (d8_out_valid === 1'b1 && d8_out_ready === 1'b1) begin
        exp_v = eq.pop_front();
        got_v = {exp_v[10:9], d8_out_cout, d8_out_sum};
`ifdef PREFIX_ADD_FLAGS_EN
        got_v[10:9] = {d8_out_ovf, d8_out_zero};
`endif
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL sweep8_beat%0d: {ovf,zero,cout,sum}=%h want %h", got, got_v, exp_v);
        end
        got++;
      end
      if (d8_in_valid === 1'b1 && d8_in_ready === 1'b1) begin
        bm = v.sub ? ~v.b : v.b;
        full = {1'b0, v.a} + {1'b0, bm} + 9'(v.sub | v.cin);
        exp_v = {(v.a[7] == bm[7]) && (full[7] != v.a[7]), full[7:0] == 8'h00, full};
        eq.push_back(exp_v);
        sent++;
      end
    end
    @(negedge clk);
    d8_in_valid = 1'b0;
    d8_out_ready = 1'b1;
    checks++;
    if (got != total) begin
      errors++;
      $display("FAIL sweep8_count: got %0d results, want %0d (cycles %0d)", got, total, cyc);
    end
    $display("test_sweep8: %0d beats over %0d cycles", got, cyc);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_reset_inflight();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
